// File: rtl/data_status_pkg.sv
// Shared types and helpers for the data/status shift-register family.
// Holds the parallel-in/serial-out FSM state encoding and the width
// derivation for the word-count field.
package data_status_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  // Width needed to hold a count in the range 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/data_status_piso_ctrl.sv
// Control path for the parallel-in/serial-out register. It owns the
// IDLE/SHIFT FSM, the remaining-word counter, the load handshake and
// the last-word marker. It also produces the load and shift enables
// that steer the slot registers in the top level.
module data_status_piso_ctrl
  import data_status_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid_i,
  input  logic             ready_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             load_ready_o,
  output logic             valid_o,
  output logic             last_o,
  output logic             load_en_o,
  output logic             shift_en_o
);

  piso_state_e      state;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] count_eff;
  logic             count_nz;
  logic             beat;
  logic             load_fire;

  // A requested count larger than the slot count cannot be honoured,
  // so it is clamped to DEPTH.
  assign count_eff    = (count_i > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : count_i;
  assign count_nz     = (count_eff != '0);
  assign beat         = valid_o & ready_i;
  // Accepting a load while the final word leaves gives back-to-back
  // vectors with no idle cycle between them.
  assign load_ready_o = (state == IDLE) | (beat & last_o);
  assign load_fire    = load_valid_i & load_ready_o;
  assign load_en_o    = load_fire & count_nz;
  assign shift_en_o   = beat & ~load_en_o;

  // FSM, remaining counter and registered valid/last outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
    end else if (load_fire) begin
      if (count_nz) begin
        state     <= SHIFT;
        remaining <= count_eff;
        valid_o   <= 1'b1;
        last_o    <= (count_eff == CNT_W'(1));
      end else begin
        state     <= IDLE;
        remaining <= '0;
        valid_o   <= 1'b0;
        last_o    <= 1'b0;
      end
    end else if (beat) begin
      if (remaining <= CNT_W'(1)) begin
        state     <= IDLE;
        remaining <= '0;
        valid_o   <= 1'b0;
        last_o    <= 1'b0;
      end else begin
        remaining <= remaining - CNT_W'(1);
        last_o    <= (remaining == CNT_W'(2));
      end
    end
  end

endmodule

// File: rtl/data_status_piso_reg.sv
// Parallel-in, serial-out data/status register. A whole vector of
// DEPTH words plus per-word status is captured in one load handshake
// and then emitted one word per accepted beat, slot 0 first, with a
// last-word marker and full backpressure.
// Optional feature macro: DATA_STATUS_PISO_REG_COUNT_EN adds the
// load_count_i port. Without it every vector emits exactly DEPTH words.
module data_status_piso_reg
  import data_status_pkg::*;
#(
  parameter  int DATA_W   = 32,
  parameter  int STATUS_W = 1,
  parameter  int DEPTH    = 4,
  localparam int CNT_W    = cnt_width(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_valid_i,
  output logic                      load_ready_o,
  input  logic [DEPTH*DATA_W-1:0]   load_data_i,
  input  logic [DEPTH*STATUS_W-1:0] load_status_i,
`ifdef DATA_STATUS_PISO_REG_COUNT_EN
  input  logic [CNT_W-1:0]          load_count_i,
`endif
  output logic [DATA_W-1:0]         data_o,
  output logic [STATUS_W-1:0]       status_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      last_o
);

  logic [DATA_W-1:0]   data_q   [DEPTH];
  logic [STATUS_W-1:0] status_q [DEPTH];
  logic [CNT_W-1:0]    count;
  logic                load_en;
  logic                shift_en;

`ifdef DATA_STATUS_PISO_REG_COUNT_EN
  assign count = load_count_i;
`else
  assign count = CNT_W'(DEPTH);
`endif

  data_status_piso_ctrl #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .load_valid_i (load_valid_i),
    .ready_i      (ready_i),
    .count_i      (count),
    .load_ready_o (load_ready_o),
    .valid_o      (valid_o),
    .last_o       (last_o),
    .load_en_o    (load_en),
    .shift_en_o   (shift_en)
  );

  // Data slots are not reset; the top slot keeps stale data on a shift
  // because it is never presented again before the next load.
  always_ff @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= load_data_i[i*DATA_W +: DATA_W];
      end
    end else if (shift_en) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        data_q[i] <= data_q[i+1];
      end
    end
  end

  // Status slots are reset and the top slot refills with zero on a shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        status_q[i] <= '0;
      end
    end else if (load_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        status_q[i] <= load_status_i[i*STATUS_W +: STATUS_W];
      end
    end else if (shift_en) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        status_q[i] <= status_q[i+1];
      end
      status_q[DEPTH-1] <= '0;
    end
  end

  assign data_o   = data_q[0];
  assign status_o = status_q[0];

endmodule

// File: tb/tb_data_status_piso_reg.sv
// Directed bench for data_status_piso_reg with DEPTH=4, DATA_W=32,
// STATUS_W=1. A per-cycle table covers the plain unload, stalls, the
// back-to-back load and a refused load; hand-written sequences cover
// reset mid-vector and, when DATA_STATUS_PISO_REG_COUNT_EN is defined,
// the count rules.
module tb_data_status_piso_reg;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [127:0] load_data;
  logic [3:0]  load_status;
`ifdef DATA_STATUS_PISO_REG_COUNT_EN
  logic [2:0]  load_count;
`endif
  logic [31:0] data;
  logic        status;
  logic        valid;
  logic        ready;
  logic        last;

  int n_cmp;
  int n_bad;

  logic [31:0]  a_words [4];
  logic [31:0]  b_words [4];
  logic [127:0] pack_a;
  logic [127:0] pack_b;
  logic [3:0]   stat_a;
  logic [3:0]   stat_b;

  typedef struct {
    logic        lv;
    logic        rdy;
    logic        sel_b;
    logic        e_valid;
    logic        e_last;
    logic        e_lr;
    logic [31:0] e_data;
    logic        e_status;
  } vec_t;

  vec_t tbl [$];

  data_status_piso_reg dut (
    .clk           (clk),
    .rst           (rst),
    .load_valid_i  (load_valid),
    .load_ready_o  (load_ready),
    .load_data_i   (load_data),
    .load_status_i (load_status),
`ifdef DATA_STATUS_PISO_REG_COUNT_EN
    .load_count_i  (load_count),
`endif
    .data_o        (data),
    .status_o      (status),
    .valid_o       (valid),
    .ready_i       (ready),
    .last_o        (last)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic lv, input logic rdy, input logic sel_b,
                              input logic ev, input logic el, input logic elr,
                              input logic [31:0] ed, input logic es);
    vec_t v;
    v.lv = lv; v.rdy = rdy; v.sel_b = sel_b;
    v.e_valid = ev; v.e_last = el; v.e_lr = elr;
    v.e_data = ed; v.e_status = es;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs just after the falling edge, then settle before sampling.
  task automatic apply_stimulus(input logic lv, input logic rdy, input logic sel_b);
    @(negedge clk);
    load_valid  = lv;
    ready       = rdy;
    load_data   = sel_b ? pack_b : pack_a;
    load_status = sel_b ? stat_b : stat_a;
    #1;
  endtask

  task automatic check_cycle(input string tag, input logic ev, input logic el, input logic elr,
                             input logic [31:0] ed, input logic es);
    check_output({tag, " valid"}, 32'(valid), 32'(ev));
    check_output({tag, " last"}, 32'(last), 32'(el));
    check_output({tag, " load_ready"}, 32'(load_ready), 32'(elr));
    if (ev) begin
      check_output({tag, " data"}, data, ed);
      check_output({tag, " status"}, 32'(status), 32'(es));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    for (int i = 0; i < 4; i++) begin
      a_words[i] = 32'hA000_0000 + 32'(i);
      b_words[i] = 32'hB000_0000 + 32'(i);
      pack_a[i*32 +: 32] = a_words[i];
      pack_b[i*32 +: 32] = b_words[i];
    end
    stat_a = 4'b1101;  // slot0..3 = 1,0,1,1
    stat_b = 4'b0110;  // slot0..3 = 0,1,1,0

    rst         = 1'b1;
    load_valid  = 1'b0;
    ready       = 1'b0;
    load_data   = pack_a;
    load_status = stat_a;
`ifdef DATA_STATUS_PISO_REG_COUNT_EN
    load_count  = 3'd4;
`endif

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check_output("reset valid", 32'(valid), 32'd0);
    check_output("reset last", 32'(last), 32'd0);
    check_output("reset load_ready", 32'(load_ready), 32'd1);
    check_output("reset status", 32'(status), 32'd0);
    rst = 1'b0;

    // lv, rdy, sel_b | valid, last, load_ready, data, status
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 32'h0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, a_words[0], 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, a_words[1], 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, a_words[2], 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1, a_words[3], 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h0, 0));
    // Reload and unload with ready toggling 1,0,0,1,...
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 32'h0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, a_words[0], 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, a_words[1], 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, a_words[1], 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, a_words[1], 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, a_words[2], 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, a_words[2], 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, a_words[2], 1));
    // B offered during a stalled A3: refused.
    tbl.push_back(mk(1, 0, 1, 1, 1, 0, a_words[3], 1));
    // A3 leaves and B is taken in the same cycle.
    tbl.push_back(mk(1, 1, 1, 1, 1, 1, a_words[3], 1));
    tbl.push_back(mk(0, 1, 1, 1, 0, 0, b_words[0], 0));
    // A offered during B1: refused, B continues.
    tbl.push_back(mk(1, 1, 0, 1, 0, 0, b_words[1], 1));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, b_words[2], 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1, b_words[3], 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 32'h0, 0));

    for (int r = 0; r < tbl.size(); r++) begin
      apply_stimulus(tbl[r].lv, tbl[r].rdy, tbl[r].sel_b);
      check_cycle($sformatf("row%0d", r), tbl[r].e_valid, tbl[r].e_last, tbl[r].e_lr,
                  tbl[r].e_data, tbl[r].e_status);
    end

    // Reset while B1 (status 1) is presented abandons the vector.
    apply_stimulus(1, 1, 1);
    apply_stimulus(0, 1, 1);
    check_cycle("rst B0", 1, 0, 0, b_words[0], 0);
    apply_stimulus(0, 0, 1);
    check_cycle("rst B1", 1, 0, 0, b_words[1], 1);
    rst = 1'b1;
    #1;
    check_output("midrst valid", 32'(valid), 32'd0);
    check_output("midrst last", 32'(last), 32'd0);
    check_output("midrst status", 32'(status), 32'd0);
    check_output("midrst load_ready", 32'(load_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(1, 1, 0);
    check_cycle("post-rst load", 0, 0, 1, 32'h0, 0);
    apply_stimulus(0, 1, 0);
    check_cycle("post-rst A0", 1, 0, 0, a_words[0], 1);
    apply_stimulus(0, 1, 0);
    check_cycle("post-rst A1", 1, 0, 0, a_words[1], 0);
    apply_stimulus(0, 1, 0);
    apply_stimulus(0, 1, 0);
    check_cycle("post-rst A3", 1, 1, 1, a_words[3], 1);
    apply_stimulus(0, 1, 0);
    check_cycle("post-rst idle", 0, 0, 1, 32'h0, 0);

`ifdef DATA_STATUS_PISO_REG_COUNT_EN
    // Count 2: two words, last on the second.
    load_count = 3'd2;
    apply_stimulus(1, 1, 0);
    check_cycle("cnt2 load", 0, 0, 1, 32'h0, 0);
    apply_stimulus(0, 1, 0);
    check_cycle("cnt2 w0", 1, 0, 0, a_words[0], 1);
    apply_stimulus(0, 1, 0);
    check_cycle("cnt2 w1", 1, 1, 1, a_words[1], 0);
    apply_stimulus(0, 1, 0);
    check_cycle("cnt2 idle", 0, 0, 1, 32'h0, 0);
    // Count 0: accepted and dropped.
    load_count = 3'd0;
    apply_stimulus(1, 1, 1);
    check_cycle("cnt0 load", 0, 0, 1, 32'h0, 0);
    apply_stimulus(0, 1, 1);
    check_cycle("cnt0 idle", 0, 0, 1, 32'h0, 0);
    // Count 7: clamped to four words.
    load_count = 3'd7;
    apply_stimulus(1, 1, 1);
    check_cycle("cnt7 load", 0, 0, 1, 32'h0, 0);
    for (int j = 0; j < 4; j++) begin
      apply_stimulus(0, 1, 1);
      check_cycle($sformatf("cnt7 w%0d", j), 1, (j == 3), (j == 3), b_words[j], stat_b[j]);
    end
    apply_stimulus(0, 1, 1);
    check_cycle("cnt7 idle", 0, 0, 1, 32'h0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_status_piso_reg.md
# data_status_piso_reg

Parallel-in, serial-out counterpart of the data/status shift-register family: accepts a vector of up to DEPTH data words with per-word status in one load handshake, then emits them one per accepted beat on a valid/ready stream. It unloads tap vectors collected by serial-in shift registers back onto a word-serial datapath, with full backpressure and a last-word marker.

## Interface
- DATA_W, 32, width of each data word
- STATUS_W, 1, width of each status word
- DEPTH, 4, number of word slots; must be ≥ 2
- CNT_W, $clog2(DEPTH+1), width of load_count_i (derived; not overridden)

- clk  in  1  clock
- rst  in  1  reset; asynchronous and active-high
- load_valid_i  in  1  load vector offered
- load_ready_o  out  1  load vector accepted this cycle when both are high
- load_data_i  in  DATA_W × [DEPTH]  words; slot 0 is emitted first
- load_status_i  in  STATUS_W × [DEPTH]  per-word status
- load_count_i  in  CNT_W  number of words to emit; present only with the count option
- data_o  out  DATA_W  current output word
- status_o  out  STATUS_W  current output status
- valid_o  out  1  output word valid
- ready_i  in  1  downstream accepts the word
- last_o  out  1  current word is the final word of the vector

## Operation
- States: IDLE (no words held) and SHIFT (remaining count ≥ 1).
- IDLE: load_ready_o = 1, valid_o = 0. A load with count n ≥ 1 captures all slots, sets remaining = n, and moves to SHIFT.
- SHIFT: valid_o = 1; data_o/status_o come from slot 0; last_o = (remaining == 1).
- Beat (valid_o & ready_i): slot[i] ← slot[i+1]; top slot status ← '0 and data is don't-care; remaining decrements.
- Last beat with no load in the same cycle: go to IDLE.
- load_ready_o = IDLE | (valid_o & ready_i & last_o). A load in the same cycle as the last beat replaces the slots and remaining directly, giving back-to-back vectors with no bubble.
- Count rules: load_count_i = 0 means the load is accepted and dropped, and the state stays or becomes IDLE. load_count_i > DEPTH is clamped to DEPTH. The decrement never wraps below 0.
- A stalled output (ready_i = 0) holds data_o, status_o, last_o and valid_o stable.
- Reset values: state IDLE, remaining 0, valid_o 0, last_o 0, load_ready_o 1 (combinational from IDLE), status slots '0, status_o '0. Data slots are not reset, so data_o is undefined until the first load and is meaningful only while valid_o is high.
- Reset asserted mid-vector abandons all remaining words immediately.

## Timing
- Load accepted at edge k: valid_o is high with word 0 from cycle k+1.
- With ready_i held high, word j appears at cycle k+1+j and last_o is high at cycle k+n.
- Throughput is one word per cycle, including across vector boundaries.
- All outputs except load_ready_o are registered. load_ready_o has a combinational path from ready_i.

## Configuration
- DATA_STATUS_PISO_REG_COUNT_EN
  - Defined: the load_count_i port exists and the count rules above apply.
  - Undefined: the port is absent and every vector emits exactly DEPTH words.

## Structure
- Shared package data_status_pkg: the piso_state_e enum (IDLE, SHIFT) and the CNT_W derivation function.
- One sub-module, data_status_piso_ctrl, owns the FSM, the remaining counter, load_ready_o, last_o and the shift/load enables.
- The top level holds the data and status slot registers. Data slots have no reset; status slots are reset.

## Test plan
- Reset, then load DEPTH=4 words A0..A3, status 1,0,1,1, with ready_i held at 1 -> A0..A3 on cycles 1–4, status 1,0,1,1, last_o only on A3, then valid_o = 0.
- Same load with ready_i toggling 1,0,0,1,… -> each word is held stable while stalled, no word is lost or duplicated, last_o is set only on A3.
- Second load offered during A3 with ready_i = 1 -> accepted in that cycle and B0 follows A3 with no idle cycle; a load offered during A1 sees load_ready_o = 0.
- With the count option defined, counts 2, 0 and 7 -> two words with last_o on the second; no output for count 0; four words for count 7 (clamped).
- rst asserted while A1 is presented -> valid_o, last_o and status_o drop to 0 immediately, load_ready_o = 1, and the next load starts cleanly at word 0.
